// File: rtl/mult_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: one shift-add or restoring
// shift-subtract step per clock on operand magnitudes, with sign fix-up at the end.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_Start,
  input  logic [1:0]            i_Op,
  input  logic [DATA_WIDTH-1:0] i_SrcA,
  input  logic [DATA_WIDTH-1:0] i_SrcB,
  input  logic                  i_HiWrite,
  input  logic                  i_LoWrite,
  input  logic [DATA_WIDTH-1:0] i_WriteData,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic                  o_DivByZero,
  output logic [DATA_WIDTH-1:0] o_HI,
  output logic [DATA_WIDTH-1:0] o_LO
);

  localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_capture;
  logic                  w_iterate;
  logic                  w_finish;

  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_is_div;
  logic                  r_sign_a;
  logic                  r_sign_b;
  logic                  r_div_zero;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_mq;
  logic [DATA_WIDTH-1:0] r_mcand;
  logic [DATA_WIDTH-1:0] r_hi;
  logic [DATA_WIDTH-1:0] r_lo;
  logic                  r_done;
  logic                  r_dbz;

  // Operand decode at start: signed ops are MULT (00) and DIV (10).
  logic                  w_signed_op;
  logic                  w_neg_a;
  logic                  w_neg_b;
  logic [DATA_WIDTH-1:0] w_mag_a;
  logic [DATA_WIDTH-1:0] w_mag_b;

  assign w_signed_op = ~i_Op[0];
  assign w_neg_a     = w_signed_op & i_SrcA[DATA_WIDTH-1];
  assign w_neg_b     = w_signed_op & i_SrcB[DATA_WIDTH-1];
  assign w_mag_a     = w_neg_a ? -i_SrcA : i_SrcA;
  assign w_mag_b     = w_neg_b ? -i_SrcB : i_SrcB;

  // Iteration datapath.
  logic [DATA_WIDTH:0]   w_mul_sum;
  logic [DATA_WIDTH:0]   w_mul_step;
  logic [DATA_WIDTH:0]   w_div_shift;
  logic [DATA_WIDTH+1:0] w_div_diff;
  logic                  w_div_borrow;

  assign w_mul_sum    = {1'b0, r_acc} + {1'b0, r_mcand};
  assign w_mul_step   = r_mq[0] ? w_mul_sum : {1'b0, r_acc};
  assign w_div_shift  = {r_acc, r_mq[DATA_WIDTH-1]};
  assign w_div_diff   = {1'b0, w_div_shift} - {2'b00, r_mcand};
  assign w_div_borrow = w_div_diff[DATA_WIDTH+1];

  // Sign correction applied on the FIN edge.
  logic                    w_neg_result;
  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [2*DATA_WIDTH-1:0] w_prod_fixed;
  logic [DATA_WIDTH-1:0]   w_quot;
  logic [DATA_WIDTH-1:0]   w_rem;

  assign w_neg_result = r_sign_a ^ r_sign_b;
  assign w_prod       = {r_acc, r_mq};
  assign w_prod_fixed = w_neg_result ? -w_prod : w_prod;
  assign w_quot       = w_neg_result ? -r_mq : r_mq;
  // With a zero divisor the remainder register ends holding |SrcA|, so this
  // same expression reconstructs the captured dividend for HI.
  assign w_rem        = r_sign_a ? -r_acc : r_acc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_iterate    = 1'b0;
    w_finish     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_Start) begin
          w_capture    = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        w_iterate = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_state_next = FIN;
        end
      end
      FIN: begin
        w_finish     = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= w_finish;
      r_dbz  <= w_finish & r_is_div & r_div_zero;

      if (w_capture) begin
        r_cnt <= '0;
      end else if (w_iterate) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end

      if (w_finish) begin
        if (r_is_div) begin
          r_hi <= w_rem;
          r_lo <= r_div_zero ? '1 : w_quot;
        end else begin
          {r_hi, r_lo} <= w_prod_fixed;
        end
      end else if (r_state == IDLE) begin
        if (i_HiWrite) begin
          r_hi <= i_WriteData;
        end
        if (i_LoWrite) begin
          r_lo <= i_WriteData;
        end
      end
    end
  end

  // NOTE: working registers carry no reset; they are always loaded on the
  // capture edge before use, and only HI/LO and control are architectural.
  always_ff @(posedge i_CLK) begin
    if (w_capture) begin
      r_is_div   <= i_Op[1];
      r_sign_a   <= w_neg_a;
      r_sign_b   <= w_neg_b;
      r_div_zero <= (i_SrcB == '0);
      r_acc      <= '0;
      r_mq       <= w_mag_a;
      r_mcand    <= w_mag_b;
    end else if (w_iterate) begin
      if (r_is_div) begin
        r_acc <= w_div_borrow ? w_div_shift[DATA_WIDTH-1:0] : w_div_diff[DATA_WIDTH-1:0];
        r_mq  <= {r_mq[DATA_WIDTH-2:0], ~w_div_borrow};
      end else begin
        r_acc <= w_mul_step[DATA_WIDTH:1];
        r_mq  <= {w_mul_step[0], r_mq[DATA_WIDTH-1:1]};
      end
    end
  end

  assign o_Busy      = (r_state != IDLE);
  assign o_Done      = r_done;
  assign o_DivByZero = r_dbz;
  assign o_HI        = r_hi;
  assign o_LO        = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (DATA_WIDTH = 32): results,
// fixed latency, divide-by-zero, MTHI/MTLO gating, back-to-back and abort.
module tb_mult_div_unit;

  localparam int DW      = 32;
  localparam int LAT     = DW + 1;  // edges after the start edge until o_Done reads 1
  localparam int TIMEOUT = 200;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = '0;
  logic [DW-1:0] src_a = '0;
  logic [DW-1:0] src_b = '0;
  logic          hi_wr = 1'b0;
  logic          lo_wr = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          busy;
  logic          done;
  logic          dbz;
  logic [DW-1:0] hi;
  logic [DW-1:0] lo;

  int errors = 0;
  int checks = 0;

  mult_div_unit #(.DATA_WIDTH(DW)) dut (
    .i_CLK       (clk),
    .i_RST       (rst),
    .i_Start     (start),
    .i_Op        (op),
    .i_SrcA      (src_a),
    .i_SrcB      (src_b),
    .i_HiWrite   (hi_wr),
    .i_LoWrite   (lo_wr),
    .i_WriteData (wdata),
    .o_Busy      (busy),
    .o_Done      (done),
    .o_DivByZero (dbz),
    .o_HI        (hi),
    .o_LO        (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until o_Done or the budget runs out; n is the edge count after the start edge.
  task automatic wait_done(input int start_n, output int n);
    n = start_n;
    while (done !== 1'b1 && n < TIMEOUT) begin
      tick();
      n++;
    end
  endtask

  // Issue one operation and return what is visible in the o_Done cycle.
  task automatic run_op(input logic [1:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        output int lat, output int busy_cycles,
                        output logic [DW-1:0] r_hi, output logic [DW-1:0] r_lo, output logic r_dbz);
    op = o; src_a = a; src_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    lat = 0;
    while (done !== 1'b1 && lat < TIMEOUT) begin
      tick();
      lat++;
      if (busy === 1'b1) busy_cycles++;
    end
    r_hi = hi; r_lo = lo; r_dbz = dbz;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (dbz  !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", dbz); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_multu_max();
    int lat, bc;
    logic [DW-1:0] rh, rl;
    logic rd;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, rh, rl, rd);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL multu_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (bc !== LAT) begin errors++; $display("FAIL multu_busy_cycles: got %0d expected %0d", bc, LAT); end
    checks++; if (rh !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_max_hi: got %h expected fffffffe", rh); end
    checks++; if (rl !== 32'h0000_0001) begin errors++; $display("FAIL multu_max_lo: got %h expected 00000001", rl); end
    checks++; if (rd !== 1'b0) begin errors++; $display("FAIL multu_dbz: got %b expected 0", rd); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b expected 0", done); end
  endtask

  task automatic test_signed_mult();
    int lat, bc;
    logic [DW-1:0] rh, rl;
    logic rd;
    run_op(OP_MULT, -32'sd3, 32'sd5, lat, bc, rh, rl, rd);
    checks++; if (rh !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_m3x5_hi: got %h expected ffffffff", rh); end
    checks++; if (rl !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_m3x5_lo: got %h expected fffffff1", rl); end
    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, lat, bc, rh, rl, rd);
    checks++; if (rh !== 32'h4000_0000) begin errors++; $display("FAIL mult_minmin_hi: got %h expected 40000000", rh); end
    checks++; if (rl !== 32'h0000_0000) begin errors++; $display("FAIL mult_minmin_lo: got %h expected 00000000", rl); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL mult_latency: got %0d expected %0d", lat, LAT); end
  endtask

  task automatic test_signed_div();
    int lat, bc;
    logic [DW-1:0] rh, rl;
    logic rd;
    run_op(OP_DIV, -32'sd7, 32'sd2, lat, bc, rh, rl, rd);
    checks++; if (rl !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_m7_2_lo: got %h expected fffffffd", rl); end
    checks++; if (rh !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_m7_2_hi: got %h expected ffffffff", rh); end
    run_op(OP_DIV, 32'sd7, -32'sd2, lat, bc, rh, rl, rd);
    checks++; if (rl !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_7_m2_lo: got %h expected fffffffd", rl); end
    checks++; if (rh !== 32'h0000_0001) begin errors++; $display("FAIL div_7_m2_hi: got %h expected 00000001", rh); end
    run_op(OP_DIV, -32'sd7, -32'sd2, lat, bc, rh, rl, rd);
    checks++; if (rl !== 32'h0000_0003) begin errors++; $display("FAIL div_m7_m2_lo: got %h expected 00000003", rl); end
    checks++; if (rh !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_m7_m2_hi: got %h expected ffffffff", rh); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL div_latency: got %0d expected %0d", lat, LAT); end
  endtask

  task automatic test_div_by_zero();
    int lat, bc;
    logic [DW-1:0] rh, rl;
    logic rd;
    run_op(OP_DIVU, 32'd10, 32'd0, lat, bc, rh, rl, rd);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL divz_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (rd !== 1'b1) begin errors++; $display("FAIL divz_flag: got %b expected 1", rd); end
    checks++; if (rl !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_lo: got %h expected ffffffff", rl); end
    checks++; if (rh !== 32'h0000_000A) begin errors++; $display("FAIL divz_hi: got %h expected 0000000a", rh); end
    tick();
    checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL divz_flag_clear: got %b expected 0", dbz); end
    run_op(OP_DIV, -32'sd5, 32'd0, lat, bc, rh, rl, rd);
    checks++; if (rd !== 1'b1) begin errors++; $display("FAIL divz_signed_flag: got %b expected 1", rd); end
    checks++; if (rl !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_signed_lo: got %h expected ffffffff", rl); end
    checks++; if (rh !== 32'hFFFF_FFFB) begin errors++; $display("FAIL divz_signed_hi: got %h expected fffffffb", rh); end
  endtask

  task automatic test_div_overflow();
    int lat, bc;
    logic [DW-1:0] rh, rl;
    logic rd;
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, rh, rl, rd);
    checks++; if (rl !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h expected 80000000", rl); end
    checks++; if (rh !== 32'h0000_0000) begin errors++; $display("FAIL div_ovf_hi: got %h expected 00000000", rh); end
    checks++; if (rd !== 1'b0) begin errors++; $display("FAIL div_ovf_flag: got %b expected 0", rd); end
  endtask

  task automatic test_ignore_during_run();
    int n;
    int extra;
    hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'h55;
    tick();
    hi_wr = 1'b0; lo_wr = 1'b0;
    checks++; if (lo !== 32'h55) begin errors++; $display("FAIL mtlo_idle: got %h expected 00000055", lo); end
    op = OP_MULTU; src_a = 32'd6; src_b = 32'd7; start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    repeat (4) tick();                        // E1..E4
    op = OP_DIV; src_a = 32'd100; src_b = 32'd3; start = 1'b1;
    tick();                                   // E5: must be ignored
    start = 1'b0;
    repeat (4) tick();                        // E6..E9
    lo_wr = 1'b1; wdata = 32'hDEAD;
    tick();                                   // E10: MTLO while running
    lo_wr = 1'b0;
    checks++; if (lo !== 32'h55) begin errors++; $display("FAIL lo_hold_in_run: got %h expected 00000055", lo); end
    checks++; if (hi !== 32'h55) begin errors++; $display("FAIL hi_hold_in_run: got %h expected 00000055", hi); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_run: got %b expected 1", busy); end
    wait_done(10, n);
    checks++; if (n !== LAT) begin errors++; $display("FAIL ignore_latency: got %0d expected %0d", n, LAT); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL ignore_hi: got %h expected 00000000", hi); end
    checks++; if (lo !== 32'd42) begin errors++; $display("FAIL ignore_lo: got %h expected 0000002a", lo); end
    extra = 0;
    repeat (2 * LAT) begin
      tick();
      if (done === 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL no_second_done: got %0d pulses expected 0", extra); end
  endtask

  task automatic test_write_with_start();
    int n;
    op = OP_MULTU; src_a = 32'd3; src_b = 32'd4; start = 1'b1;
    lo_wr = 1'b1; wdata = 32'hABCD;
    tick();
    start = 1'b0; lo_wr = 1'b0;
    checks++; if (lo !== 32'hABCD) begin errors++; $display("FAIL write_with_start_lo: got %h expected 0000abcd", lo); end
    wait_done(0, n);
    checks++; if (lo !== 32'd12) begin errors++; $display("FAIL write_then_result_lo: got %h expected 0000000c", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL write_then_result_hi: got %h expected 00000000", hi); end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    hi_wr = 1'b1; wdata = 32'h1234;
    tick();
    hi_wr = 1'b0;
    checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mthi: got %h expected 00001234", hi); end
    op = OP_MULTU; src_a = 32'd2; src_b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(0, n);
    checks++; if (lo !== 32'd6) begin errors++; $display("FAIL b2b_first_lo: got %h expected 00000006", lo); end
    op = OP_DIVU; src_a = 32'd9; src_b = 32'd4; start = 1'b1;   // issued in the o_Done cycle
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accepted: got busy=%b expected 1", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_clear: got %b expected 0", done); end
    wait_done(0, n);
    checks++; if (n !== LAT) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", n, LAT); end
    checks++; if (lo !== 32'd2) begin errors++; $display("FAIL b2b_divu_lo: got %h expected 00000002", lo); end
    checks++; if (hi !== 32'd1) begin errors++; $display("FAIL b2b_divu_hi: got %h expected 00000001", hi); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    int lat, bc, pulses;
    logic [DW-1:0] rh, rl;
    logic rd;
    hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'h77;
    tick();
    hi_wr = 1'b0; lo_wr = 1'b0;
    op = OP_DIV; src_a = 32'd1000; src_b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL abort_hi: got %h expected 00000000", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL abort_lo: got %h expected 00000000", lo); end
    tick();
    rst = 1'b0;
    pulses = 0;
    repeat (2 * LAT) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", pulses); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL abort_lo_stays: got %h expected 00000000", lo); end
    run_op(OP_DIV, 32'sd100, -32'sd7, lat, bc, rh, rl, rd);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL after_abort_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (rl !== 32'hFFFF_FFF2) begin errors++; $display("FAIL after_abort_lo: got %h expected fffffff2", rl); end
    checks++; if (rh !== 32'h0000_0002) begin errors++; $display("FAIL after_abort_hi: got %h expected 00000002", rh); end
  endtask

  initial begin
    #1;
    test_reset();
    test_multu_max();
    test_signed_mult();
    test_signed_div();
    test_div_by_zero();
    test_div_overflow();
    test_ignore_during_run();
    test_write_with_start();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
